fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side adapter for the shallow synchronous distributed-RAM FIFO. It pops words through the FIFO's `rd_en`/`empty`/`rd_data` port, where `rd_data` is combinational from the read pointer. It presents the words as a valid/ready stream through a registered 2-entry output buffer, with optional fixed-length burst framing (`m_last`). It sits between the FIFO and any downstream consumer that needs backpressure and registered outputs.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `BURST_LEN`, 16, beats per burst for `m_last` generation; ≥2.
- `BEAT_WIDTH`, `$clog2(BURST_LEN)`, width of the internal beat counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO head word, combinational, valid while `!fifo_empty`.
- `fifo_rd_en`  out  1  pop request to FIFO (combinational).
- `m_valid`  out  1  output word valid (registered).
- `m_ready`  in  1  consumer accept.
- `m_data`  out  DATA_WIDTH  output word (registered).
- `m_last`  out  1  final beat of a burst (registered; see Configuration).
- `flush`  in  1  synchronous discard of buffered words and burst state.
- `buf_count`  out  2  occupancy of output buffer, 0..2.

## Operation
- Buffer: two registers, `main` (drives `m_data`) and `skid`. Occupancy `occ` ∈ {0,1,2}. `m_valid = (occ != 0)`. `buf_count = occ`.
- Pop: `fifo_rd_en = !fifo_empty && (occ < 2) && !flush && !rst`. The decision uses registered `occ` only; it never depends on `m_ready`.
- Handshake: a beat transfers when `m_valid && m_ready`. `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- Per-edge update with pop `p = fifo_rd_en` and take `t = m_valid && m_ready`:
  - occ 0: if p, main←fifo_rd_data, occ→1.
  - occ 1, t&p: main←fifo_rd_data, occ stays 1.
  - occ 1, t&!p: occ→0.
  - occ 1, !t&p: skid←fifo_rd_data, occ→2.
  - occ 2, t: main←skid, occ→1 (p is 0 by construction).
  - occ 2, !t: hold.
- Ordering: words leave in exactly FIFO order. No word is dropped or duplicated except by `flush`/`rst`.
- Burst framing: the beat counter counts accepted beats from 0 to BURST_LEN-1 and wraps to 0. The `m_last` tag is computed when a word enters the buffer, from the count of words loaded so far, and is stored alongside the data in main/skid.
- Flush: while `flush` is high, `fifo_rd_en`=0. At the edge, occ→0 and the beat counter and load counter →0. FIFO contents are untouched.
- Reset: `m_valid`=0, `m_data`=0, `m_last`=0, `buf_count`=0, counters=0. `fifo_rd_en` is 0 while `rst` is high. `rst` has priority over `flush`.

## Timing
- Latency: if `fifo_empty` falls before edge N, `fifo_rd_en`=1 in cycle N-1→N and `m_valid`=1 after edge N. That is one cycle from FIFO non-empty to stream valid.
- Throughput: 1 word/cycle sustained with `m_ready` held high and FIFO non-empty (steady occ=1).
- Backpressure: after `m_ready` drops, at most one further word is popped (into skid); `fifo_rd_en` is then 0 until a beat is taken.
- Reset or flush applied mid-burst: the next burst starts at beat 0 and the first post-flush word is beat 0.

## Configuration
- `FIFO_READER_LAST_EN` defined: the load counter, the per-entry last tags and the `m_last` logic are compiled in. `m_last` is asserted on every BURST_LEN-th delivered word.
- Not defined: the counters and tags are removed and `m_last` is tied to 0. All other behaviour is identical.

## Test plan
- Reset: hold `rst` for 3 cycles with FIFO non-empty → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `buf_count`=0 throughout. The first pop occurs in the cycle after `rst` falls.
- Streaming: 40 words 0x00..0x27 with `m_ready`=1 → after a 1-cycle fill, 40 consecutive beats in order, `buf_count`=1 steady. With the macro and BURST_LEN=16, `m_last` is high on 0x0F and 0x1F only.
- Backpressure: FIFO holds 0xA0..0xA4 and `m_ready`=0 for 5 cycles → exactly 2 pops, `buf_count`=2, `m_data`=0xA0 stable. On release, 0xA0..0xA4 are delivered in order with no gaps after the first.
- Empty boundary: 1 word 0x5A is written, then FIFO is empty, with `m_ready` toggling 1/0 → single beat 0x5A. `fifo_rd_en` never asserts while `fifo_empty`=1, and `m_valid` drops the cycle after the take.
- Flush mid-burst: flush for 1 cycle after 5 beats with occ=2 → `m_valid`=0 next cycle and the two buffered words are discarded. The next delivered word is the FIFO head and counts as beat 0, so `m_last` falls on its 16th beat.
- Macro off: repeat the streaming test → identical data sequence, `m_last` constantly 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Purpose : read-side adapter that pops a combinational-read FIFO into a registered 2-entry valid/ready buffer.
// Latency : one cycle from FIFO non-empty to m_valid; 1 word/cycle sustained while m_ready stays high.
// Backpr. : pop decision uses buffer occupancy only; at most one extra word lands in skid after m_ready drops.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset (rst wins over flush)
//   fifo_empty        - FIFO empty flag
//   fifo_rd_data      - FIFO head word, combinational from the FIFO read pointer
//   fifo_rd_en        - pop request to the FIFO (combinational)
//   m_valid/m_ready   - output stream handshake (m_valid registered)
//   m_data, m_last    - output word and end-of-burst tag (registered)
//   flush             - discard buffered words and restart burst framing
//   buf_count         - output buffer occupancy, 0..2
//
// Build option: define FIFO_READER_LAST_EN to compile in burst framing on m_last;
// without it m_last is tied low and everything else behaves the same.

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int BEAT_WIDTH = $clog2(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  flush,
  output logic [1:0]            buf_count
);

  // Parameter sanity: framing needs at least two beats and a counter wide enough.
  if (BURST_LEN < 2 || BEAT_WIDTH != $clog2(BURST_LEN)) begin : g_cfg_check
    $error("fifo_stream_reader: BURST_LEN must be >= 2 and BEAT_WIDTH == $clog2(BURST_LEN)");
  end

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  occ_e                  r_occ;
  occ_e                  w_occ_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_pop;
  logic                  w_take;
  logic                  w_main_from_fifo;
  logic                  w_main_from_skid;
  logic                  w_skid_from_fifo;

  // Pop only on registered occupancy so the FIFO never sees a path from m_ready.
  assign w_pop      = !fifo_empty && (r_occ != OCC_2) && !flush && !rst;
  assign w_take     = (r_occ != OCC_0) && m_ready;
  assign fifo_rd_en = w_pop;
  assign m_valid    = (r_occ != OCC_0);
  assign m_data     = r_main;
  assign buf_count  = r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= OCC_0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  always_comb begin
    w_occ_nxt        = r_occ;
    w_main_from_fifo = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_fifo = 1'b0;
    if (flush) begin
      w_occ_nxt = OCC_0;
    end else begin
      case (r_occ)
        OCC_0: begin
          if (w_pop) begin
            w_main_from_fifo = 1'b1;
            w_occ_nxt        = OCC_1;
          end
        end
        OCC_1: begin
          if (w_take && w_pop) begin
            w_main_from_fifo = 1'b1;
          end else if (w_take) begin
            w_occ_nxt = OCC_0;
          end else if (w_pop) begin
            w_skid_from_fifo = 1'b1;
            w_occ_nxt        = OCC_2;
          end
        end
        OCC_2: begin
          // w_pop is necessarily 0 here, so skid simply shifts forward.
          if (w_take) begin
            w_main_from_skid = 1'b1;
            w_occ_nxt        = OCC_1;
          end
        end
        default: w_occ_nxt = OCC_0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_fifo) begin
        r_main <= fifo_rd_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_fifo) begin
        r_skid <= fifo_rd_data;
      end
    end
  end

`ifdef FIFO_READER_LAST_EN
  localparam int LW = BEAT_WIDTH + 1;

  logic [BEAT_WIDTH-1:0] r_beat_cnt;
  logic [LW-1:0]         w_load_sum;
  logic [LW-1:0]         w_load_cnt;
  logic                  w_load_last;
  logic                  r_main_last;
  logic                  r_skid_last;

  // Words loaded so far = words accepted + words still buffered, so the load
  // counter is derived from the beat counter and occupancy (mod BURST_LEN).
  assign w_load_sum  = LW'(r_beat_cnt) + LW'(buf_count);
  assign w_load_cnt  = (w_load_sum >= LW'(BURST_LEN)) ? (w_load_sum - LW'(BURST_LEN)) : w_load_sum;
  assign w_load_last = (w_load_cnt == LW'(BURST_LEN - 1));
  assign m_last      = r_main_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_main_last <= 1'b0;
      r_skid_last <= 1'b0;
    end else if (flush) begin
      r_beat_cnt  <= '0;
      r_main_last <= 1'b0;
      r_skid_last <= 1'b0;
    end else begin
      if (w_take) begin
        r_beat_cnt <= (r_beat_cnt == BEAT_WIDTH'(BURST_LEN - 1)) ? '0 : (r_beat_cnt + BEAT_WIDTH'(1));
      end
      if (w_main_from_fifo) begin
        r_main_last <= w_load_last;
      end else if (w_main_from_skid) begin
        r_main_last <= r_skid_last;
      end
      if (w_skid_from_fifo) begin
        r_skid_last <= w_load_last;
      end
    end
  end
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Purpose : directed self-checking bench for fifo_stream_reader with a behavioural FIFO model.
// Latency : inputs change 1ns after the rising edge; outputs are sampled on the falling edge or after edges settle.
// Backpr. : m_ready is driven per phase to exercise fill, stall, release and empty conditions.

module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 16;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          flush;
  logic [1:0]    buf_count;

  logic [DW-1:0] fq[$];     // FIFO contents
  logic [DW-1:0] exp_q[$];  // words still expected on the stream, in order
  int            n_cmp;
  int            n_err;
  int            n_takes;
  int            n_pops;
  int            n_last;
  int            exp_beat;
  logic [DW-1:0] last_dat;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .flush       (flush),
    .buf_count   (buf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_last();
`ifdef FIFO_READER_LAST_EN
    return (exp_beat == BL - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic fifo_upd();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_upd();
  endtask

  // One clock: sample handshakes on the falling edge, score beats, then apply
  // the pop to the FIFO model just after the rising edge.
  task automatic step();
    logic s_pop;
    logic s_take;
    logic s_clr;
    @(negedge clk);
    s_pop  = fifo_rd_en;
    s_take = m_valid && m_ready;
    s_clr  = rst || flush;
    if (s_pop) begin
      n_pops++;
      if (fifo_empty) chk("pop_while_empty", 32'(fifo_empty), 32'd0);
    end
    if (s_take) begin
      n_takes++;
      if (m_last) begin
        n_last++;
        last_dat = m_data;
      end
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("beat_last", 32'(m_last), 32'(exp_last()));
        chk("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      exp_beat = (exp_beat == BL - 1) ? 0 : exp_beat + 1;
    end
    if (s_clr) exp_beat = 0;
    @(posedge clk);
    #1;
    if (s_pop && fq.size() != 0) void'(fq.pop_front());
    fifo_upd();
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    n_takes  = 0;
    n_pops   = 0;
    n_last   = 0;
    exp_beat = 0;
    last_dat = '0;
    rst      = 1'b1;
    flush    = 1'b0;
    m_ready  = 1'b1;
    fifo_upd();

    // Reset held with the FIFO non-empty: nothing may pop or appear.
    push(8'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'h00);
      chk("rst_count", 32'(buf_count), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rst_first_pop", 32'(fifo_rd_en), 32'd1);
    step();
    chk("rst_fill_valid", 32'(m_valid), 32'd1);
    chk("rst_fill_data", 32'(m_data), 32'h11);
    step();
    chk("rst_drain_valid", 32'(m_valid), 32'd0);

    // Streaming 0x00..0x27 with m_ready high, burst framing restarted by reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) push(8'(i));
    n_takes = 0;
    n_last  = 0;
    step();
    chk("stream_fill_valid", 32'(m_valid), 32'd1);
    chk("stream_fill_data", 32'(m_data), 32'h00);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("stream_count", 32'(buf_count), (i < 39) ? 32'd1 : 32'd0);
    end
    chk("stream_beats", 32'(n_takes), 32'd40);
`ifdef FIFO_READER_LAST_EN
    chk("stream_last_n", 32'(n_last), 32'd2);
    chk("stream_last_dat", 32'(last_dat), 32'h1F);
`else
    chk("stream_last_n", 32'(n_last), 32'd0);
`endif

    // Backpressure: 5 words queued, consumer stalled for 5 cycles.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    n_pops = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", 32'(m_data), 32'hA0);
    end
    chk("bp_pops", 32'(n_pops), 32'd2);
    chk("bp_count", 32'(buf_count), 32'd2);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    n_takes = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_flow", 32'(n_takes), 32'(i + 1));
    end
    chk("bp_drained", 32'(buf_count), 32'd0);

    // Empty boundary: a single word with m_ready toggling.
    m_ready = 1'b0;
    push(8'h5A);
    step();
    chk("eb_valid", 32'(m_valid), 32'd1);
    chk("eb_data", 32'(m_data), 32'h5A);
    chk("eb_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    chk("eb_hold", 32'(buf_count), 32'd1);
    m_ready = 1'b1;
    n_takes = 0;
    step();
    chk("eb_drop", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    step();
    m_ready = 1'b1;
    step();
    chk("eb_beats", 32'(n_takes), 32'd1);
    chk("eb_idle", 32'(m_valid), 32'd0);

    // Flush mid-burst with two words buffered.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 32; i++) push(8'h60 + 8'(i));
    n_takes = 0;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("fl_pre_beats", 32'(n_takes), 32'd5);
    m_ready = 1'b0;
    step();
    chk("fl_pre_count", 32'(buf_count), 32'd2);
    chk("fl_pre_data", 32'(m_data), 32'h65);
    flush = 1'b1;
    #1;
    chk("fl_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    flush = 1'b0;
    chk("fl_valid", 32'(m_valid), 32'd0);
    chk("fl_count", 32'(buf_count), 32'd0);
    // 0x65 and 0x66 were sitting in the buffer and are gone.
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    n_takes = 0;
    n_last  = 0;
    for (int i = 0; i < 26; i++) step();
    chk("fl_post_beats", 32'(n_takes), 32'd25);
`ifdef FIFO_READER_LAST_EN
    chk("fl_last_n", 32'(n_last), 32'd1);
    chk("fl_last_dat", 32'(last_dat), 32'h76);
`else
    chk("fl_last_n", 32'(n_last), 32'd0);
`endif
    chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("end_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("end_valid", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
